// File: rtl/ll_pkg.sv
// Shared types and sizing for the linked-list free-pointer manager.
package ll_pkg;
   localparam int PTR_W = 4;
   localparam int DEPTH = 2**PTR_W;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;
endpackage

// File: rtl/ll_free_list_if.sv
// Free/alloc handshake and status bundle of ll_free_list.
interface ll_free_list_if;
   import ll_pkg::*;

   logic [PTR_W-1:0] in_ptr;
   logic             in_ptr_vld;
   logic             in_ptr_rdy;
   logic             alloc_req;
   logic [PTR_W-1:0] alloc_ptr;
   logic             alloc_vld;
   logic [PTR_W:0]   free_cnt;
   logic             empty;
   logic             init_done;
   logic             err_dbl_free;
   logic             err_alloc;

   modport master (
      output in_ptr, in_ptr_vld, alloc_req,
      input  in_ptr_rdy, alloc_ptr, alloc_vld, free_cnt,
      input  empty, init_done, err_dbl_free, err_alloc
   );

   modport slave (
      input  in_ptr, in_ptr_vld, alloc_req,
      output in_ptr_rdy, alloc_ptr, alloc_vld, free_cnt,
      output empty, init_done, err_dbl_free, err_alloc
   );
endinterface

// File: rtl/ll_next_ram.sv
// Next-pointer RAM: one synchronous write port, one combinational read port.
module ll_next_ram
   import ll_pkg::*;
(
   input  logic             clk,
   input  logic             i_we,
   input  logic [PTR_W-1:0] i_waddr,
   input  logic [PTR_W-1:0] i_wdata,
   input  logic [PTR_W-1:0] i_raddr,
   output logic [PTR_W-1:0] o_rdata
);
   logic [PTR_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ll_free_list.sv
// Free-pointer manager: unused nodes form a singly linked list in ll_next_ram.
module ll_free_list
   import ll_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   ll_free_list_if.slave bus
);
   state_t             r_state;
   state_t             w_state_nxt;
   logic [PTR_W-1:0]   r_init_idx;
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [PTR_W:0]     r_free_cnt;
   logic [DEPTH-1:0]   r_used;
   logic [PTR_W-1:0]   r_alloc_ptr;
   logic               r_alloc_vld;
   logic               r_err_dbl;
   logic               r_err_alloc;

   logic               w_run;
   logic               w_init;
   logic               w_last;
   logic               w_cnt0;
   logic               w_cnt1;
   logic               w_alloc;
   logic               w_alloc_err;
   logic               w_free_try;
   logic               w_free;
   logic               w_dbl;
   logic               w_we;
   logic [PTR_W-1:0]   w_waddr;
   logic [PTR_W-1:0]   w_wdata;
   logic [PTR_W-1:0]   w_next_rd;
   logic [PTR_W-1:0]   w_head_nxt;
   logic [PTR_W-1:0]   w_tail_nxt;
   logic [PTR_W:0]     w_cnt_nxt;

   assign w_run  = (r_state == ST_RUN);
   assign w_init = (r_state == ST_INIT);
   assign w_last = (r_init_idx == PTR_W'(DEPTH-1));
   assign w_cnt0 = (r_free_cnt == '0);
   assign w_cnt1 = (r_free_cnt == (PTR_W+1)'(1));

   assign w_alloc     = w_run && bus.alloc_req && !w_cnt0;
   assign w_alloc_err = w_run && bus.alloc_req && w_cnt0;
   assign w_free_try  = w_run && bus.in_ptr_vld;
   assign w_free      = w_free_try && r_used[bus.in_ptr];
   assign w_dbl       = w_free_try && !r_used[bus.in_ptr];

   assign w_we    = w_init || w_free;
   assign w_waddr = w_init ? r_init_idx : r_tail;
   assign w_wdata = w_init ? r_init_idx + 1'b1 : bus.in_ptr;

   ll_next_ram u_next_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (r_head),
      .o_rdata (w_next_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_INIT: if (w_last) w_state_nxt = ST_RUN;
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // A lone remaining node (or none) makes the freed pointer the new head;
   // its stale next entry must not be followed.
   always_comb begin
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      w_cnt_nxt  = r_free_cnt;
      if (w_init) begin
         if (w_last) begin
            w_head_nxt = '0;
            w_tail_nxt = PTR_W'(DEPTH-1);
            w_cnt_nxt  = (PTR_W+1)'(DEPTH);
         end
      end else begin
         if (w_alloc) w_head_nxt = w_next_rd;
         if (w_free) begin
            w_tail_nxt = bus.in_ptr;
            if (w_cnt0 || (w_alloc && w_cnt1))
               w_head_nxt = bus.in_ptr;
         end
         unique case (1'b1)
            w_free && !w_alloc: w_cnt_nxt = r_free_cnt + 1'b1;
            w_alloc && !w_free: w_cnt_nxt = r_free_cnt - 1'b1;
            default:            w_cnt_nxt = r_free_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_init_idx  <= '0;
         r_head      <= '0;
         r_tail      <= PTR_W'(DEPTH-1);
         r_free_cnt  <= '0;
         r_used      <= '0;
         r_alloc_ptr <= '0;
         r_alloc_vld <= 1'b0;
         r_err_dbl   <= 1'b0;
         r_err_alloc <= 1'b0;
      end else begin
         if (w_init) r_init_idx <= r_init_idx + 1'b1;
         r_head      <= w_head_nxt;
         r_tail      <= w_tail_nxt;
         r_free_cnt  <= w_cnt_nxt;
         r_alloc_vld <= w_alloc;
         r_err_dbl   <= w_dbl;
         r_err_alloc <= w_alloc_err;
         if (w_alloc) begin
            r_alloc_ptr    <= r_head;
            r_used[r_head] <= 1'b1;
         end
         if (w_free) r_used[bus.in_ptr] <= 1'b0;
      end
   end

   // empty is qualified with RUN so every output reads 0 straight out of reset.
   assign bus.in_ptr_rdy   = w_run;
   assign bus.init_done    = w_run;
   assign bus.empty        = w_run && w_cnt0;
   assign bus.alloc_ptr    = r_alloc_ptr;
   assign bus.alloc_vld    = r_alloc_vld;
   assign bus.free_cnt     = r_free_cnt;
   assign bus.err_dbl_free = r_err_dbl;
   assign bus.err_alloc    = r_err_alloc;
endmodule
